// File: rtl/led_pkg.sv
// Shared mode encoding for the multi-channel LED driver.
package led_pkg;

    typedef logic [1:0] led_mode_t;

    localparam led_mode_t MODE_OFF     = 2'd0;
    localparam led_mode_t MODE_ON      = 2'd1;
    localparam led_mode_t MODE_BLINK   = 2'd2;
    localparam led_mode_t MODE_BREATHE = 2'd3;

endpackage

// File: rtl/led_ctrl_multi_if.sv
// Configuration write bus: the control source is master, the LED driver is slave.
interface led_ctrl_multi_if
    import led_pkg::*;
#(
    parameter int CH_W     = 2,
    parameter int PER_BITS = 16
);

    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    led_mode_t           cfg_mode;
    logic [PER_BITS-1:0] cfg_period;

    modport master (output cfg_we, cfg_ch, cfg_mode, cfg_period);
    modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_period);

endinterface

// File: rtl/led_channel.sv
// One LED channel: stored mode/period, tick timebase, blink phase and
// breathe duty ramp, producing an unregistered drive bit.
module led_channel
    import led_pkg::*;
#(
    parameter int        PWM_BITS       = 8,
    parameter int        PER_BITS       = 16,
    parameter led_mode_t DEFAULT_MODE   = MODE_BLINK,
    parameter int        DEFAULT_PERIOD = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  led_mode_t           wr_mode,
    input  logic [PER_BITS-1:0] wr_period,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                drive
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    led_mode_t           mode;
    logic [PER_BITS-1:0] period;
    logic [PER_BITS-1:0] cnt;
    logic                phase;
    logic [PWM_BITS-1:0] duty;
    logic                dir_up;

    logic [PER_BITS-1:0] eff_period;
    logic [PER_BITS:0]   cnt_inc;
    logic                step;

    // A stored period of zero behaves as one tick.
    always_comb begin
        eff_period = (period == '0) ? PER_BITS'(1) : period;
        cnt_inc    = {1'b0, cnt} + (PER_BITS + 1)'(1);
        step       = tick && (cnt_inc == {1'b0, eff_period});
    end

    // A write restarts the channel and swallows a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode   <= DEFAULT_MODE;
            period <= PER_BITS'(DEFAULT_PERIOD);
            cnt    <= '0;
            phase  <= 1'b1;
            duty   <= '0;
            dir_up <= 1'b1;
        end else if (we) begin
            mode   <= wr_mode;
            period <= wr_period;
            cnt    <= '0;
            phase  <= 1'b1;
            duty   <= '0;
            dir_up <= 1'b1;
        end else if (tick) begin
            cnt <= step ? '0 : cnt_inc[PER_BITS-1:0];
            if (step && mode == MODE_BLINK) begin
                phase <= ~phase;
            end
            if (step && mode == MODE_BREATHE) begin
                if (dir_up) begin
                    if (duty == DUTY_MAX) begin
                        dir_up <= 1'b0;
                        duty   <= DUTY_MAX - PWM_BITS'(1);
                    end else begin
                        duty <= duty + PWM_BITS'(1);
                    end
                end else begin
                    if (duty == '0) begin
                        dir_up <= 1'b1;
                        duty   <= PWM_BITS'(1);
                    end else begin
                        duty <= duty - PWM_BITS'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        drive = 1'b0;
        case (mode)
            MODE_OFF:     drive = 1'b0;
            MODE_ON:      drive = 1'b1;
            MODE_BLINK:   drive = phase;
            MODE_BREATHE: drive = (pwm_cnt < duty);
            default:      drive = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_ctrl_multi.sv
// Multi-channel LED driver: shared tick prescaler and PWM counter, per-channel
// mode engines, and a registered LED output.
module led_ctrl_multi
    import led_pkg::*;
#(
    parameter int CH_NUM         = 4,
    parameter int TICK_DIV       = 50000,
    parameter int PWM_BITS       = 8,
    parameter int PER_BITS       = 16,
    parameter int DEFAULT_MODE   = 2,
    parameter int DEFAULT_PERIOD = 500
) (
    input  logic              clk,
    input  logic              rst,
    led_ctrl_multi_if.slave   cfg,
    output logic [CH_NUM-1:0] led,
    output logic              tick
);

    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]    presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [CH_NUM-1:0]   ch_we;
    logic [CH_NUM-1:0]   drive;

    assign tick = (presc == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc   <= tick ? '0 : presc + PRE_W'(1);
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Out-of-range channel indices match no instance, so such writes are dropped.
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        assign ch_we[i] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

        led_channel #(
            .PWM_BITS       (PWM_BITS),
            .PER_BITS       (PER_BITS),
            .DEFAULT_MODE   (led_mode_t'(DEFAULT_MODE)),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .we        (ch_we[i]),
            .wr_mode   (cfg.cfg_mode),
            .wr_period (cfg.cfg_period),
            .tick      (tick),
            .pwm_cnt   (pwm_cnt),
            .drive     (drive[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= drive;
        end
    end

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Randomised and directed bench for led_ctrl_multi; a four-channel and a
// three-channel instance share one config stream against an arithmetic model.
module tb_led_ctrl_multi;

    localparam int TICK_DIV   = 4;
    localparam int PWM_BITS   = 4;
    localparam int PER_BITS   = 8;
    localparam int DEF_MODE   = 2;
    localparam int DEF_PERIOD = 2;
    localparam int DUTY_MAX   = (1 << PWM_BITS) - 1;
    localparam int CH_A       = 4;
    localparam int CH_B       = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CH_A-1:0] led_a;
    logic [CH_B-1:0] led_b;
    logic tick_a;
    logic tick_b;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode  [2][4];
    int m_per   [2][4];
    int m_ticks [2][4];
    int m_cyc;
    logic [3:0] exp_led [2];
    logic exp_tick;

    led_ctrl_multi_if #(.CH_W(2), .PER_BITS(PER_BITS)) cfg_a ();
    led_ctrl_multi_if #(.CH_W(2), .PER_BITS(PER_BITS)) cfg_b ();

    always #5 clk = ~clk;

    led_ctrl_multi #(
        .CH_NUM(CH_A), .TICK_DIV(TICK_DIV), .PWM_BITS(PWM_BITS),
        .PER_BITS(PER_BITS), .DEFAULT_MODE(DEF_MODE), .DEFAULT_PERIOD(DEF_PERIOD)
    ) dut_a (
        .clk(clk), .rst(rst), .cfg(cfg_a.slave), .led(led_a), .tick(tick_a)
    );

    led_ctrl_multi #(
        .CH_NUM(CH_B), .TICK_DIV(TICK_DIV), .PWM_BITS(PWM_BITS),
        .PER_BITS(PER_BITS), .DEFAULT_MODE(DEF_MODE), .DEFAULT_PERIOD(DEF_PERIOD)
    ) dut_b (
        .clk(clk), .rst(rst), .cfg(cfg_b.slave), .led(led_b), .tick(tick_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Output level from counted ticks: blink phase and a triangular duty wave.
    function automatic logic modelDrive(input int mode, input int per, input int n, input int pwm);
        int p;
        int steps;
        int s;
        int duty;
        p     = (per == 0) ? 1 : per;
        steps = n / p;
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((steps % 2) == 0);
            default: begin
                s    = steps % (2 * DUTY_MAX);
                duty = (s <= DUTY_MAX) ? s : 2 * DUTY_MAX - s;
                return (pwm < duty);
            end
        endcase
    endfunction

    function automatic void modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_mode[d][c]  = DEF_MODE;
                m_per[d][c]   = DEF_PERIOD;
                m_ticks[d][c] = 0;
            end
            exp_led[d] = '0;
        end
        m_cyc    = 0;
        exp_tick = 1'b0;
    endfunction

    function automatic void modelStep(input logic we, input int ch, input int mode, input int per);
        int  pwm;
        bit  tk;
        int  chn;
        pwm = m_cyc % (1 << PWM_BITS);
        tk  = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
        for (int d = 0; d < 2; d++) begin
            chn = (d == 0) ? CH_A : CH_B;
            for (int c = 0; c < chn; c++) begin
                exp_led[d][c] = modelDrive(m_mode[d][c], m_per[d][c], m_ticks[d][c], pwm);
                if (we && ch == c) begin
                    m_mode[d][c]  = mode;
                    m_per[d][c]   = per;
                    m_ticks[d][c] = 0;
                end else if (tk) begin
                    m_ticks[d][c]++;
                end
            end
        end
        m_cyc++;
        exp_tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
    endfunction

    // One clock: present the write, let the edge happen, then compare.
    task automatic applyStimulus(input logic we, input logic [1:0] ch, input logic [1:0] mode,
                                 input logic [PER_BITS-1:0] per);
        cfg_a.cfg_we     = we;
        cfg_a.cfg_ch     = ch;
        cfg_a.cfg_mode   = mode;
        cfg_a.cfg_period = per;
        cfg_b.cfg_we     = we;
        cfg_b.cfg_ch     = ch;
        cfg_b.cfg_mode   = mode;
        cfg_b.cfg_period = per;
        @(posedge clk);
        modelStep(we, int'(ch), int'(mode), int'(per));
        #1;
        checkOutput("led_a", 32'(led_a), 32'(exp_led[0]));
        checkOutput("led_b", 32'(led_b), 32'(exp_led[1][CH_B-1:0]));
        checkOutput("tick_a", 32'(tick_a), 32'(exp_tick));
        checkOutput("tick_b", 32'(tick_b), 32'(exp_tick));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, 2'd0, 2'd0, '0);
        end
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_led_a", 32'(led_a), 32'd0);
        checkOutput("rst_led_b", 32'(led_b), 32'd0);
        checkOutput("rst_tick", 32'(tick_a), 32'd0);
        modelReset();
        repeat (cycles) @(negedge clk);
        checkOutput("rst_hold_led_a", 32'(led_a), 32'd0);
        checkOutput("rst_hold_tick", 32'(tick_b), 32'd0);
        rst = 1'b0;
    endtask

    task automatic idleUntilTick();
        for (int i = 0; i < TICK_DIV && !exp_tick; i++) begin
            applyStimulus(1'b0, 2'd0, 2'd0, '0);
        end
        checkOutput("tick_align", 32'(tick_a), 32'd1);
    endtask

    initial begin
        cfg_a.cfg_we = 1'b0; cfg_a.cfg_ch = '0; cfg_a.cfg_mode = '0; cfg_a.cfg_period = '0;
        cfg_b.cfg_we = 1'b0; cfg_b.cfg_ch = '0; cfg_b.cfg_mode = '0; cfg_b.cfg_period = '0;
        modelReset();

        doReset(10);
        idle(20);

        applyStimulus(1'b1, 2'd1, 2'd1, 8'd2);
        idle(3);
        applyStimulus(1'b1, 2'd2, 2'd0, 8'd2);
        idle(3);
        // Channel 3 is out of range for the three-channel instance.
        applyStimulus(1'b1, 2'd3, 2'd1, 8'd2);
        idle(3);

        applyStimulus(1'b1, 2'd0, 2'd2, 8'd3);
        idle(40);
        applyStimulus(1'b1, 2'd0, 2'd2, 8'd0);
        idle(20);

        applyStimulus(1'b1, 2'd3, 2'd3, 8'd1);
        applyStimulus(1'b1, 2'd2, 2'd3, 8'd1);
        idle(160);

        idleUntilTick();
        applyStimulus(1'b1, 2'd0, 2'd2, 8'd2);
        idle(30);

        applyStimulus(1'b1, 2'd2, 2'd3, 8'd1);
        idle(50);
        doReset(3);
        idle(20);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                              PER_BITS'($urandom_range(0, 4)));
            end else begin
                applyStimulus(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                              PER_BITS'($urandom_range(0, 4)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
